// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer around an external combinational ALU: reads operands
// from a small register file, drives the ALU from registers, retires result and Z/C/N flags.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package config_pkg;
  typedef enum logic [3:0] {
    ADD = 4'd0,
    ADC = 4'd1,
    SUB = 4'd2,
    CMP = 4'd3,
    INC = 4'd4,
    DEC = 4'd5,
    AND = 4'd6,
    OR  = 4'd7,
    XOR = 4'd8,
    SHR = 4'd9,
    SHL = 4'd10
  } opcode_t;
endpackage

module alu_sequencer
  import config_pkg::*;
#(
  parameter int WORD_SIZE  = `WORD_SIZE,
  parameter int REG_COUNT  = 8,
  parameter int REG_ADDR_W = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  opcode_t               in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rx,
  input  logic [REG_ADDR_W-1:0] in_ry,
  output logic [WORD_SIZE-1:0]  alu_a,
  output logic [WORD_SIZE-1:0]  alu_b,
  output opcode_t               alu_opcode,
  input  logic [WORD_SIZE-1:0]  alu_out,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_n,
  output logic                  done,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [WORD_SIZE-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t                  state_r;
  opcode_t                 op_r;
  logic [REG_ADDR_W-1:0]   rx_r;
  logic [REG_ADDR_W-1:0]   ry_r;
  logic [WORD_SIZE-1:0]    regs_r [REG_COUNT];
  logic [WORD_SIZE-1:0]    result_r;
  logic [2:0]              pend_flags_r;
  logic [2:0]              flags_r;
  logic                    ready_r;
  logic                    done_r;
  logic [WORD_SIZE-1:0]    alu_a_r;
  logic [WORD_SIZE-1:0]    alu_b_r;
  opcode_t                 alu_op_r;
  logic                    accept_s;
  logic                    reg_we_s;

  // Flag set {z, c, n}; carry/borrow evaluated over WORD_SIZE+1 bits.
  function automatic logic [2:0] calc_flags(input opcode_t op,
                                            input logic [WORD_SIZE-1:0] a,
                                            input logic [WORD_SIZE-1:0] b,
                                            input logic [WORD_SIZE-1:0] res);
    logic [WORD_SIZE:0] sum_w;
    logic [WORD_SIZE:0] diff_w;
    logic               z;
    logic               c;
    logic               n;
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} - {1'b0, b};
    z      = (res == {WORD_SIZE{1'b0}});
    n      = res[WORD_SIZE-1];
    c      = 1'b0;
    case (op)
      ADD, ADC: c = (sum_w > {1'b0, {WORD_SIZE{1'b1}}});
      SUB:      c = diff_w[WORD_SIZE];
      CMP: begin
        z = (diff_w == {(WORD_SIZE+1){1'b0}});
        c = diff_w[WORD_SIZE];
        n = diff_w[WORD_SIZE-1];
      end
      INC:      c = &a;
      DEC:      c = ~|a;
      default:  c = 1'b0;
    endcase
    return {z, c, n};
  endfunction

  function automatic logic writes_back(input opcode_t op);
    case (op)
      ADD, ADC, SUB, INC, DEC, AND, OR, XOR, SHR, SHL: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  // CMP updates flags without a result write; anything unlisted touches neither.
  function automatic logic updates_flags(input opcode_t op);
    case (op)
      CMP:     return 1'b1;
      default: return writes_back(op);
    endcase
  endfunction

  // Handshake and write-enable decode.
  always_comb begin
    accept_s = in_valid && ready_r;
    reg_we_s = 1'b0;
    if (state_r == WB) begin
      reg_we_s = writes_back(op_r);
    end else begin
      reg_we_s = 1'b0;
    end
  end

  // Sequencer FSM with ALU operand, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      op_r         <= ADD;
      rx_r         <= {REG_ADDR_W{1'b0}};
      ry_r         <= {REG_ADDR_W{1'b0}};
      result_r     <= {WORD_SIZE{1'b0}};
      pend_flags_r <= 3'b000;
      flags_r      <= 3'b000;
      ready_r      <= 1'b1;
      done_r       <= 1'b0;
      alu_a_r      <= {WORD_SIZE{1'b0}};
      alu_b_r      <= {WORD_SIZE{1'b0}};
      alu_op_r     <= ADD;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r    <= in_opcode;
            rx_r    <= in_rx;
            ry_r    <= in_ry;
            ready_r <= 1'b0;
            state_r <= READ;
          end
        end
        READ: begin
          alu_a_r  <= regs_r[rx_r];
          alu_b_r  <= regs_r[ry_r];
          alu_op_r <= op_r;
          state_r  <= EXEC;
        end
        EXEC: begin
          result_r     <= alu_out;
          pend_flags_r <= calc_flags(alu_op_r, alu_a_r, alu_b_r, alu_out);
          state_r      <= WB;
        end
        WB: begin
          if (updates_flags(op_r)) begin
            flags_r <= pend_flags_r;
          end
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Register file, written only from the WB state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {WORD_SIZE{1'b0}};
      end
    end else if (reg_we_s) begin
      regs_r[rx_r] <= result_r;
    end
  end

  assign in_ready   = ready_r;
  assign done       = done_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_opcode = alu_op_r;
  assign flag_z     = flags_r[2];
  assign flag_c     = flags_r[1];
  assign flag_n     = flags_r[0];
  assign dbg_data   = regs_r[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus an instruction-level
// reference model of the register file and flags, directed cases then random traffic.
module tb_alu_sequencer;
  import config_pkg::*;

  localparam int W    = 8;
  localparam int NREG = 8;
  localparam int MASK = 255;
  localparam int HALF = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  opcode_t     in_opcode;
  logic [2:0]  in_rx;
  logic [2:0]  in_ry;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  opcode_t     alu_opcode;
  logic [7:0]  alu_out;
  logic        flag_z;
  logic        flag_c;
  logic        flag_n;
  logic        done;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int ref_regs [NREG];
  bit ref_z, ref_c, ref_n;

  alu_sequencer #(.WORD_SIZE(W), .REG_COUNT(NREG), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rx(in_rx), .in_ry(in_ry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational ALU.
  always_comb begin
    case (alu_opcode)
      ADD, ADC: alu_out = alu_a + alu_b;
      SUB, CMP: alu_out = alu_a - alu_b;
      INC:      alu_out = alu_a + 8'd1;
      DEC:      alu_out = alu_a - 8'd1;
      AND:      alu_out = alu_a & alu_b;
      OR:       alu_out = alu_a | alu_b;
      XOR:      alu_out = alu_a ^ alu_b;
      SHR:      alu_out = alu_a >> 1;
      SHL:      alu_out = alu_a << 1;
      default:  alu_out = 8'h00;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input int idx, input string tag);
    dbg_addr = 3'(idx);
    #1;
    check_eq(tag, 32'(dbg_data), 32'(ref_regs[idx]));
  endtask

  task automatic check_flags(input string tag);
    check_eq(tag, 32'({flag_z, flag_c, flag_n}), 32'({ref_z, ref_c, ref_n}));
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) ref_regs[i] = 0;
    ref_z = 1'b0; ref_c = 1'b0; ref_n = 1'b0;
  endfunction

  // Instruction-level semantics in plain integer arithmetic.
  function automatic void model_exec(input opcode_t op, input int rx, input int ry);
    int a, b, r;
    bit wr, known, z, c, n;
    a = ref_regs[rx]; b = ref_regs[ry];
    r = 0; wr = 1'b1; known = 1'b1; z = 1'b0; c = 1'b0; n = 1'b0;
    case (op)
      ADD, ADC: begin r = (a + b) & MASK; c = (a + b) > MASK; end
      SUB:      begin r = (a - b) & MASK; c = a < b; end
      CMP:      begin wr = 1'b0; z = (a == b); c = a < b; n = ((a - b) & MASK) >= HALF; end
      INC:      begin r = (a + 1) & MASK; c = (a == MASK); end
      DEC:      begin r = (a - 1) & MASK; c = (a == 0); end
      AND:      r = a & b;
      OR:       r = a | b;
      XOR:      r = a ^ b;
      SHR:      r = a / 2;
      SHL:      r = (a * 2) & MASK;
      default:  begin wr = 1'b0; known = 1'b0; end
    endcase
    if (wr) begin
      z = (r == 0);
      n = (r >= HALF);
      ref_regs[rx] = r;
    end
    if (known) begin
      ref_z = z; ref_c = c; ref_n = n;
    end
  endfunction

  // Entered just after the accepting edge T; checks the pipeline up to T+4.
  task automatic track(input opcode_t op, input int rx, input int ry);
    int ea, eb;
    ea = ref_regs[rx];
    eb = ref_regs[ry];
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("done_t1", 32'(done), 32'd0);
    check_eq("ready_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("alu_a", 32'(alu_a), 32'(ea));
    check_eq("alu_b", 32'(alu_b), 32'(eb));
    check_eq("alu_opcode", 32'(alu_opcode), 32'(op));
    check_eq("done_t2", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("done_t3", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("done_wb", 32'(done), 32'd1);
    check_eq("ready_wb", 32'(in_ready), 32'd1);
    model_exec(op, rx, ry);
    check_flags("flags_wb");
    check_reg(rx, "reg_wb");
    @(negedge clk);
    check_eq("done_t5", 32'(done), 32'd0);
  endtask

  task automatic issue(input opcode_t op, input int rx, input int ry);
    int n;
    in_valid  = 1'b1;
    in_opcode = op;
    in_rx     = 3'(rx);
    in_ry     = 3'(ry);
    n = 0;
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      track(op, rx, ry);
    end
  endtask

  // Builds a value from zero using XOR/SHL/INC.
  task automatic load_reg(input int r, input int val);
    logic [7:0] v;
    bit started;
    v = 8'(val);
    started = 1'b0;
    issue(XOR, r, r);
    for (int b = 7; b >= 0; b--) begin
      if (started) issue(SHL, r, r);
      if (v[b]) begin
        issue(INC, r, r);
        started = 1'b1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    rst = 1'b1; in_valid = 1'b0; in_opcode = ADD; in_rx = 3'd0; in_ry = 3'd0; dbg_addr = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
    check_eq("rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("rst_alu_b", 32'(alu_b), 32'd0);
    check_eq("rst_alu_op", 32'(alu_opcode), 32'(ADD));
    for (int i = 0; i < NREG; i++) check_reg(i, "rst_reg");

    load_reg(1, 8'h05);
    load_reg(2, 8'h03);
    issue(SUB, 1, 2);
    dbg_addr = 3'd1; #1;
    check_eq("sub_r1", 32'(dbg_data), 32'h02);
    check_eq("sub_flags", 32'({flag_z, flag_c, flag_n}), 32'b000);

    load_reg(1, 8'hF0);
    load_reg(2, 8'h20);
    issue(ADD, 1, 2);
    dbg_addr = 3'd1; #1;
    check_eq("add_r1", 32'(dbg_data), 32'h10);
    check_eq("add_flags", 32'({flag_z, flag_c, flag_n}), 32'b010);
    issue(CMP, 1, 1);
    dbg_addr = 3'd1; #1;
    check_eq("cmp_r1", 32'(dbg_data), 32'h10);
    check_eq("cmp_flags", 32'({flag_z, flag_c, flag_n}), 32'b100);

    issue(XOR, 3, 3);
    issue(DEC, 3, 3);
    dbg_addr = 3'd3; #1;
    check_eq("dec_r3", 32'(dbg_data), 32'hFF);
    check_eq("dec_flags", 32'({flag_z, flag_c, flag_n}), 32'b011);

    // Back-to-back: INC R3 (wraps to 0) with ADD R2,R2 held behind it.
    in_valid = 1'b1; in_opcode = INC; in_rx = 3'd3; in_ry = 3'd3;
    @(posedge clk);
    @(negedge clk);
    in_opcode = ADD; in_rx = 3'd2; in_ry = 3'd2;
    gap = 0;
    while (!in_ready && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    check_eq("b2b_gap", 32'(gap), 32'd3);
    check_eq("b2b_done", 32'(done), 32'd1);
    model_exec(INC, 3, 3);
    check_flags("inc_wrap_flags");
    check_eq("inc_wrap_exp", 32'({flag_z, flag_c, flag_n}), 32'b110);
    check_reg(3, "inc_wrap_r3");
    @(posedge clk);
    track(ADD, 2, 2);
    dbg_addr = 3'd2; #1;
    check_eq("dbl_r2", 32'(dbg_data), 32'h40);

    // Reset while the instruction is in EXEC.
    load_reg(4, 8'h12);
    load_reg(5, 8'h34);
    issue(XOR, 6, 6);
    issue(DEC, 6, 6);
    in_valid = 1'b1; in_opcode = ADD; in_rx = 3'd4; in_ry = 3'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("rstx_done", 32'(done), 32'd0);
    check_eq("rstx_ready", 32'(in_ready), 32'd1);
    check_flags("rstx_flags");
    check_reg(4, "rstx_r4");
    check_reg(5, "rstx_r5");
    check_reg(6, "rstx_r6");
    @(negedge clk);
    check_eq("rstx_no_done", 32'(done), 32'd0);

    // Undefined opcode: done pulses, register and flags untouched.
    load_reg(6, 8'h77);
    issue(XOR, 7, 7);
    issue(DEC, 7, 7);
    issue(opcode_t'(4'hF), 6, 6);
    dbg_addr = 3'd6; #1;
    check_eq("unk_r6", 32'(dbg_data), 32'h77);
    check_eq("unk_flags", 32'({flag_z, flag_c, flag_n}), 32'b011);

    for (int k = 0; k < 60; k++) begin
      issue(opcode_t'(4'($urandom_range(15, 0))), int'($urandom_range(7, 0)),
            int'($urandom_range(7, 0)));
    end
    for (int i = 0; i < NREG; i++) check_reg(i, "final_reg");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue/writeback stage wrapped around the existing combinational ALU.
- Accepts one decoded register-register instruction (opcode, rx, ry) per handshake.
- Reads operands from an internal register file and drives the ALU operand/opcode inputs from registers.
- Captures the ALU result, computes Z/C/N flags, and writes the result back to rx. The ALU is instantiated alongside this block, not inside it.

Parameters:
- WORD_SIZE, `WORD_SIZE (8), datapath and register width; must match the ALU.
- REG_COUNT, 8, number of general registers R0..R(REG_COUNT-1).
- REG_ADDR_W, $clog2(REG_COUNT), register index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction.
- in_opcode  in  opcode_t  operation (enum from config.sv).
- in_rx  in  REG_ADDR_W  destination and first source register.
- in_ry  in  REG_ADDR_W  second source register.
- alu_a  out  WORD_SIZE  registered operand A to ALU.
- alu_b  out  WORD_SIZE  registered operand B to ALU.
- alu_opcode  out  opcode_t  registered opcode to ALU.
- alu_out  in  WORD_SIZE  ALU result (combinational).
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- flag_n  out  1  negative flag (result MSB).
- done  out  1  one-cycle pulse when an instruction retires.
- dbg_addr  in  REG_ADDR_W  debug register-file read index.
- dbg_data  out  WORD_SIZE  R[dbg_addr], combinational read of the current contents.

Behaviour:
- Reset, synchronous: all registers R* = 0, flags = 0, state = IDLE, done = 0, alu_a/alu_b = 0, alu_opcode = ADD.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- in_ready = 1 only in IDLE. An instruction is accepted on a clk edge with in_valid && in_ready; opcode, rx and ry are latched at that edge.
- READ: alu_a <= R[rx], alu_b <= R[ry], alu_opcode <= latched opcode.
- EXEC: result_q <= alu_out; flags computed from alu_a/alu_b/alu_out and latched into a pending set.
- WB: R[rx] <= result_q unless the opcode is CMP or unknown; the flags register takes the pending set; done = 1 for this cycle only.
- Latency and throughput: accepted at edge T, done high in the cycle after edge T+3, register and flags visible after edge T+3. Maximum throughput is one instruction per 4 cycles.
- Flag rules (W = WORD_SIZE), computed over W+1 bits:
  - ADD/ADC: C = carry out of alu_a+alu_b.
  - SUB: C = (alu_a < alu_b), unsigned borrow.
  - CMP: Z = (alu_a == alu_b), C = (alu_a < alu_b), N = alu_a-alu_b MSB; no writeback.
  - INC: C = (alu_a == all-ones).
  - DEC: C = (alu_a == 0).
  - AND/OR/XOR/SHR/SHL: C = 0.
  - Z = (alu_out == 0) and N = alu_out[W-1] for every op except CMP.
- ADC does not add the carry flag; it is identical to ADD in this revision.
- Unknown opcode: no register write, flags unchanged, done still pulses.
- rx == ry is legal: both operands read the same register, e.g. ADD R2,R2 doubles R2.
- Wrap-around: results are truncated to W bits, e.g. INC 0xFF -> 0x00 with Z=1, C=1.
- rst during READ/EXEC/WB: the instruction is dropped, no writeback, no done, state IDLE, all registers cleared.
- in_valid while not in IDLE is ignored; upstream must hold it until in_ready.
- dbg_data reflects a write in the cycle after the WB edge.

Test Plan:
- After reset, scan dbg_addr 0..7 -> all dbg_data = 0x00; flags 0; in_ready = 1.
- Seed R1=0x05, R2=0x03 (dbg preload via prior ADD/INC sequence); issue SUB R1,R2 -> done 4 cycles after accept, R1=0x02, Z=0, C=0, N=0.
- R1=0xF0, R2=0x20, ADD R1,R2 -> R1=0x10, C=1, Z=0, N=0; then CMP R1,R1 -> R1 unchanged 0x10, Z=1, C=0.
- R3=0x00, DEC R3 -> R3=0xFF, C=1, N=1, Z=0; back-to-back in_valid held high -> second instruction accepted only when in_ready returns, 4 cycles apart.
- Issue ADD R4,R5, assert rst during EXEC -> no done pulse, R4=0, state IDLE, in_ready=1 next cycle.
- Drive an undefined opcode on R6=0x77 -> done pulses, R6=0x77, flags unchanged.
